// File: rtl/scarv_cop_issue.sv
// scarv_cop_issue: host-side initiator of the CPU-to-COP instruction interface.
// Takes one ISE instruction at a time from the CPU, forwards the encoding and
// rs1 to the coprocessor, waits for its response and returns writeback data
// and status to the CPU. Non-ISE opcodes are rejected locally with status 6.
//
// Optional feature macro: SCARV_COP_ISSUE_TIMEOUT_EN
//   When defined, a WAIT-state response timeout aborts with status 7 and the
//   late response is later consumed and discarded (stale flag).
//
// Ports:
//   g_clk, g_rst          clock, asynchronous active-high reset
//   cpu_insn_*            instruction request from the CPU (ack is combinational)
//   cop_insn_*            instruction offered to the coprocessor
//   cop_rsp_*             coprocessor response
//   cpu_rsp_*             response returned to the CPU
//   cpu_busy              block is not idle
module scarv_cop_issue #(
  parameter logic [6:0]  COP_OPCODE     = 7'b0101011,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_insn_rs1,
  output logic        cop_insn_valid,
  input  logic        cop_insn_ready,
  output logic [31:0] cop_insn_enc,
  output logic [31:0] cop_insn_rs1,
  input  logic        cop_rsp_valid,
  output logic        cop_rsp_ready,
  input  logic        cop_rsp_wen,
  input  logic [31:0] cop_rsp_wdata,
  input  logic [2:0]  cop_rsp_status,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic        cpu_rsp_wen,
  output logic [4:0]  cpu_rsp_rd,
  output logic [31:0] cpu_rsp_wdata,
  output logic [2:0]  cpu_rsp_status,
  output logic        cpu_busy
);

  localparam int unsigned CntW = 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] ST_REJECT  = 3'd6;
  localparam logic [2:0] ST_TIMEOUT = 3'd7;

  // Elaboration-time range check on the timeout parameter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("scarv_cop_issue: TIMEOUT_CYCLES must be in 1..1023");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_is_cop;
  logic        w_rsp_take;
  logic        w_timeout;
  logic        w_stale;

  logic [31:0] r_cop_enc;
  logic [31:0] r_cop_rs1;
  logic        r_rsp_wen;
  logic [4:0]  r_rsp_rd;
  logic [31:0] r_rsp_wdata;
  logic [2:0]  r_rsp_status;

`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
  logic [CntW-1:0] r_cnt;
  logic            r_stale;

  assign w_stale   = r_stale;
  // Abort at the end of the TIMEOUT_CYCLES-th WAIT cycle without a usable response.
  assign w_timeout = (r_state == S_WAIT) && !w_rsp_take &&
                     (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter (cleared outside WAIT) and stale-response flag.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      r_cnt   <= '0;
      r_stale <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + CntW'(1) : '0;
      if (w_timeout)
        r_stale <= 1'b1;
      else if (r_stale && cop_rsp_valid)
        r_stale <= 1'b0;
    end
  end
`else
  assign w_stale   = 1'b0;
  assign w_timeout = 1'b0;
`endif

  // Handshake decodes; ack is gated by reset so outputs read idle during reset.
  assign w_accept   = (r_state == S_IDLE) && cpu_insn_req && !g_rst;
  assign w_is_cop   = (cpu_insn_enc[6:0] == COP_OPCODE);
  // A response seen while stale is the aborted one and is dropped.
  assign w_rsp_take = (r_state == S_WAIT) && cop_rsp_valid && !w_stale;

  // State register.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_is_cop ? S_ISSUE : S_RESP;
      S_ISSUE: if (cop_insn_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_rsp_take || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  if (cpu_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction and response payload registers.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      r_cop_enc    <= '0;
      r_cop_rs1    <= '0;
      r_rsp_wen    <= 1'b0;
      r_rsp_rd     <= '0;
      r_rsp_wdata  <= '0;
      r_rsp_status <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_rd <= cpu_insn_enc[11:7];
        if (w_is_cop) begin
          r_cop_enc <= cpu_insn_enc;
          r_cop_rs1 <= cpu_insn_rs1;
        end else begin
          r_rsp_wen    <= 1'b0;
          r_rsp_wdata  <= '0;
          r_rsp_status <= ST_REJECT;
        end
      end
      if (w_rsp_take) begin
        r_rsp_wen    <= cop_rsp_wen;
        r_rsp_wdata  <= cop_rsp_wdata;
        r_rsp_status <= cop_rsp_status;
      end else if (w_timeout) begin
        r_rsp_wen    <= 1'b0;
        r_rsp_wdata  <= '0;
        r_rsp_status <= ST_TIMEOUT;
      end
    end
  end

  assign cpu_insn_ack   = w_accept;
  assign cop_insn_valid = (r_state == S_ISSUE);
  assign cop_insn_enc   = r_cop_enc;
  assign cop_insn_rs1   = r_cop_rs1;
  assign cop_rsp_ready  = (r_state == S_WAIT) || w_stale;
  assign cpu_rsp_valid  = (r_state == S_RESP);
  assign cpu_rsp_wen    = r_rsp_wen;
  assign cpu_rsp_rd     = r_rsp_rd;
  assign cpu_rsp_wdata  = r_rsp_wdata;
  assign cpu_rsp_status = r_rsp_status;
  assign cpu_busy       = (r_state != S_IDLE);

endmodule
